qbus_block_master: RTL and testbench

QBUS_BLOCK_MASTER -- requirements
Module: qbus_block_master

---
 rtl/qbus_pkg.sv | 43 ++++
 rtl/qbus_sync.sv | 25 ++
 rtl/qbus_block_master.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_qbus_block_master.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/qbus_pkg.sv
// Shared definitions for the QBUS block-mode DMA master.
// Holds the one-hot state index constants, the fixed bus timing constants
// (in clocks) and the default reply timeout.
package qbus_pkg;

  // Index of each state's bit in the one-hot state vector.
  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_REQ        = 4'd1,
    S_ACQ        = 4'd2,
    S_ADDR_HOLD  = 4'd3,
    S_READ       = 4'd4,
    S_RDATA      = 4'd5,
    S_RDONE      = 4'd6,
    S_WSETUP     = 4'd7,
    S_WRITE      = 4'd8,
    S_WDONE      = 4'd9,
    S_RPLY_CLEAR = 4'd10,
    S_REARB      = 4'd11,
    S_ABORT      = 4'd12,
    S_RELEASE    = 4'd13
  } state_idx_e;

  localparam int NUM_STATES = 14;
  typedef logic [NUM_STATES-1:0] state_t;

  // Bus timing, in clocks.
  localparam int ACQ_CLKS       = 3;  // TSACK to TSYNC
  localparam int ADDR_HOLD_CLKS = 2;  // address hold after TSYNC
  localparam int DESKEW_CLKS    = 2;  // write data deskew before TDOUT
  localparam int REARB_CLKS     = 3;  // TSYNC negated before next address

  localparam int NXM_CYCLES_DEF = 200;

  // One-hot vector with only state s set.
  function automatic state_t st(input state_idx_e s);
    state_t v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/qbus_sync.sv
// Multi-flop synchronizer for one asynchronous bus line.
// Ports: clk, rst (async, active-high, clears the chain), d (async input),
// q (synchronized output, DEPTH clocks of latency).
module qbus_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] sync_q;
  logic [DEPTH-1:0] sync_d;

  always_comb sync_d = {sync_q[DEPTH-2:0], d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= sync_d;
  end

  assign q = sync_q[DEPTH-1];

endmodule

// File: rtl/qbus_block_master.sv
// QBUS DMA master with block-mode transfers.
// Arbitrates for the bus (TDMR/RDMGI/TSACK), runs an address phase, then
// one or more DATI/DATO data phases. When the slave asserts RREF the next
// word reuses the open TSYNC cycle (block mode); otherwise the master drops
// TSYNC and readdresses while keeping bus mastership (TSACK).
// Ports:
//   clk, RINIT (async active-high reset)
//   RSYNC/RRPLY/RREF/RDMGI : received bus lines
//   TSYNC/TDIN/TDOUT/TDMR/TSACK/TBS7/TDMGO : driven bus lines
//   start/write/words : transfer request; busy/done/nxm : status
//   assert_addr/assert_data/latch_read_data/next_word : datapath controls
module qbus_block_master
  import qbus_pkg::*;
#(
  parameter int CLK_NS     = 50,
  parameter int NXM_CYCLES = NXM_CYCLES_DEF,
  parameter int MAX_WORDS  = 16,
  parameter int CW         = 5
) (
  input  logic          clk,
  input  logic          RINIT,
  input  logic          RSYNC,
  input  logic          RRPLY,
  input  logic          RREF,
  input  logic          RDMGI,
  output logic          TSYNC,
  output logic          TDIN,
  output logic          TDOUT,
  output logic          TDMR,
  output logic          TSACK,
  output logic          TBS7,
  output logic          TDMGO,
  input  logic          start,
  input  logic          write,
  input  logic [CW-1:0] words,
  output logic          busy,
  output logic          done,
  output logic          nxm,
  output logic          assert_addr,
  output logic          assert_data,
  output logic          latch_read_data,
  output logic          next_word
);

  localparam int TW = $clog2(NXM_CYCLES + 1);

  if (CLK_NS < 1 || NXM_CYCLES < 1 || MAX_WORDS >= (1 << CW)) begin : g_bad_params
    $error("qbus_block_master: bad parameters");
  end

  // ---------------- synchronizers ----------------
  logic s_rsync, s_rrply, s_rref, s_rdmgi, s_tdmgo;
  logic tdmgo;

  qbus_sync #(.DEPTH(2)) u_sync_rsync (.clk(clk), .rst(RINIT), .d(RSYNC), .q(s_rsync));
  qbus_sync #(.DEPTH(2)) u_sync_rrply (.clk(clk), .rst(RINIT), .d(RRPLY), .q(s_rrply));
  qbus_sync #(.DEPTH(2)) u_sync_rref  (.clk(clk), .rst(RINIT), .d(RREF),  .q(s_rref));
  qbus_sync #(.DEPTH(3)) u_sync_rdmgi (.clk(clk), .rst(RINIT), .d(RDMGI), .q(s_rdmgi));
  qbus_sync #(.DEPTH(2)) u_sync_tdmgo (.clk(clk), .rst(RINIT), .d(tdmgo), .q(s_tdmgo));

  // ---------------- state ----------------
  state_t          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [TW-1:0]   timer_q, timer_d, timer_dec;
  logic [CW-1:0]   remaining_q, remaining_d;
  logic            write_q, write_d;
  logic            cont_q, cont_d;
  logic            armed_q, armed_d;
  logic            tsync_q, tsync_d, tdin_q, tdin_d, tdout_q, tdout_d;
  logic            tdmr_q, tdmr_d, tsack_q, tsack_d, tbs7_q, tbs7_d;
  logic            busy_q, busy_d, done_q, done_d, nxm_q, nxm_d;
  logic            assert_addr_q, assert_addr_d, assert_data_q, assert_data_d;
  logic            latch_q, latch_d, next_word_q, next_word_d;

  // Grant passes straight through while we are not requesting.
  assign tdmgo = RDMGI & ~RINIT & state_q[S_IDLE];

  function automatic logic [CW-1:0] clamp_words(input logic [CW-1:0] w);
    if (w == '0)                  return CW'(1);
    else if (w > CW'(MAX_WORDS))  return CW'(MAX_WORDS);
    else                          return w;
  endfunction

  assign timer_dec = timer_q - TW'(1);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    timer_d       = timer_q;
    remaining_d   = remaining_q;
    write_d       = write_q;
    cont_d        = cont_q;
    armed_d       = armed_q;
    tsync_d       = tsync_q;
    tdin_d        = tdin_q;
    tdout_d       = tdout_q;
    tdmr_d        = tdmr_q;
    tsack_d       = tsack_q;
    tbs7_d        = tbs7_q;
    busy_d        = busy_q;
    nxm_d         = nxm_q;
    assert_addr_d = assert_addr_q;
    assert_data_d = assert_data_q;
    done_d        = 1'b0;
    latch_d       = 1'b0;
    next_word_d   = 1'b0;

    if (!$onehot(state_q)) begin
      // Corrupted state register: drop off the bus and go idle.
      state_d       = st(S_IDLE);
      tsync_d       = 1'b0;
      tdin_d        = 1'b0;
      tdout_d       = 1'b0;
      tdmr_d        = 1'b0;
      tsack_d       = 1'b0;
      tbs7_d        = 1'b0;
      busy_d        = 1'b0;
      assert_addr_d = 1'b0;
      assert_data_d = 1'b0;
      remaining_d   = '0;
      timer_d       = '0;
    end else begin
      case (1'b1)
        state_q[S_IDLE]: begin
          if (start) begin
            write_d     = write;
            remaining_d = clamp_words(words);
            tdmr_d      = 1'b1;
            nxm_d       = 1'b0;
            busy_d      = 1'b1;
            // A grant already present at request time belongs to someone
            // downstream; only a grant seen after a low period is ours.
            armed_d     = ~s_rdmgi;
            state_d     = st(S_REQ);
          end
        end
        state_q[S_REQ]: begin
          if (!s_rdmgi) armed_d = 1'b1;
          if (armed_q && s_rdmgi && !s_tdmgo && !s_rsync && !s_rrply) begin
            tdmr_d        = 1'b0;
            tsack_d       = 1'b1;
            assert_addr_d = 1'b1;
            tbs7_d        = (remaining_q > CW'(1));
            cnt_d         = 2'(ACQ_CLKS - 1);
            state_d       = st(S_ACQ);
          end
        end
        state_q[S_ACQ]: begin
          if (cnt_q == 2'd0) begin
            tsync_d = 1'b1;
            cnt_d   = 2'(ADDR_HOLD_CLKS - 1);
            state_d = st(S_ADDR_HOLD);
          end else cnt_d = cnt_q - 2'd1;
        end
        state_q[S_ADDR_HOLD]: begin
          if (cnt_q == 2'd0) begin
            assert_addr_d = 1'b0;
            tbs7_d        = 1'b0;
            if (write_q) begin
              assert_data_d = 1'b1;
              cnt_d         = 2'(DESKEW_CLKS - 1);
              state_d       = st(S_WSETUP);
            end else begin
              tdin_d  = 1'b1;
              timer_d = TW'(NXM_CYCLES);
              state_d = st(S_READ);
            end
          end else cnt_d = cnt_q - 2'd1;
        end
        state_q[S_READ]: begin
          timer_d = timer_dec;
          if (s_rrply) begin
            latch_d = 1'b1;
            state_d = st(S_RDATA);
          end else if (timer_dec == '0) begin
            tdin_d  = 1'b0;
            state_d = st(S_ABORT);
          end
        end
        state_q[S_RDATA]: begin
          tdin_d  = 1'b0;
          cont_d  = s_rref;
          state_d = st(S_RDONE);
        end
        state_q[S_RDONE]: state_d = st(S_RPLY_CLEAR);
        state_q[S_WSETUP]: begin
          if (cnt_q == 2'd0) begin
            tdout_d = 1'b1;
            timer_d = TW'(NXM_CYCLES);
            state_d = st(S_WRITE);
          end else cnt_d = cnt_q - 2'd1;
        end
        state_q[S_WRITE]: begin
          timer_d = timer_dec;
          if (s_rrply) begin
            tdout_d = 1'b0;
            cont_d  = s_rref;
            state_d = st(S_WDONE);
          end else if (timer_dec == '0) begin
            tdout_d = 1'b0;
            state_d = st(S_ABORT);
          end
        end
        state_q[S_WDONE]: begin
          assert_data_d = 1'b0;
          state_d       = st(S_RPLY_CLEAR);
        end
        state_q[S_RPLY_CLEAR]: begin
          if (!s_rrply) begin
            next_word_d = 1'b1;
            remaining_d = remaining_q - CW'(1);
            if (remaining_q <= CW'(1)) begin
              tsync_d = 1'b0;
              state_d = st(S_RELEASE);
            end else if (cont_q) begin
              // Block mode: next data phase inside the same TSYNC cycle.
              if (write_q) begin
                assert_data_d = 1'b1;
                cnt_d         = 2'(DESKEW_CLKS - 1);
                state_d       = st(S_WSETUP);
              end else begin
                tdin_d  = 1'b1;
                timer_d = TW'(NXM_CYCLES);
                state_d = st(S_READ);
              end
            end else begin
              tsync_d = 1'b0;
              cnt_d   = 2'(REARB_CLKS - 1);
              state_d = st(S_REARB);
            end
          end
        end
        state_q[S_REARB]: begin
          // Still bus master (TSACK held): straight back to addressing.
          if (cnt_q == 2'd0) begin
            assert_addr_d = 1'b1;
            tbs7_d        = (remaining_q > CW'(1));
            cnt_d         = 2'(ACQ_CLKS - 1);
            state_d       = st(S_ACQ);
          end else cnt_d = cnt_q - 2'd1;
        end
        state_q[S_ABORT]: begin
          nxm_d         = 1'b1;
          tsync_d       = 1'b0;
          tdin_d        = 1'b0;
          tdout_d       = 1'b0;
          assert_data_d = 1'b0;
          assert_addr_d = 1'b0;
          remaining_d   = '0;
          state_d       = st(S_RELEASE);
        end
        state_q[S_RELEASE]: begin
          tsack_d = 1'b0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = st(S_IDLE);
        end
        default: state_d = st(S_IDLE);
      endcase
    end
  end

  always_ff @(posedge clk or posedge RINIT) begin
    if (RINIT) begin
      state_q       <= st(S_IDLE);
      cnt_q         <= '0;
      timer_q       <= '0;
      remaining_q   <= '0;
      write_q       <= 1'b0;
      cont_q        <= 1'b0;
      armed_q       <= 1'b0;
      tsync_q       <= 1'b0;
      tdin_q        <= 1'b0;
      tdout_q       <= 1'b0;
      tdmr_q        <= 1'b0;
      tsack_q       <= 1'b0;
      tbs7_q        <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      nxm_q         <= 1'b0;
      assert_addr_q <= 1'b0;
      assert_data_q <= 1'b0;
      latch_q       <= 1'b0;
      next_word_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      timer_q       <= timer_d;
      remaining_q   <= remaining_d;
      write_q       <= write_d;
      cont_q        <= cont_d;
      armed_q       <= armed_d;
      tsync_q       <= tsync_d;
      tdin_q        <= tdin_d;
      tdout_q       <= tdout_d;
      tdmr_q        <= tdmr_d;
      tsack_q       <= tsack_d;
      tbs7_q        <= tbs7_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      nxm_q         <= nxm_d;
      assert_addr_q <= assert_addr_d;
      assert_data_q <= assert_data_d;
      latch_q       <= latch_d;
      next_word_q   <= next_word_d;
    end
  end

  assign TSYNC           = tsync_q;
  assign TDIN            = tdin_q;
  assign TDOUT           = tdout_q;
  assign TDMR            = tdmr_q;
  assign TSACK           = tsack_q;
  assign TBS7            = tbs7_q;
  assign TDMGO           = tdmgo;
  assign busy            = busy_q;
  assign done            = done_q;
  assign nxm             = nxm_q;
  assign assert_addr     = assert_addr_q;
  assign assert_data     = assert_data_q;
  assign latch_read_data = latch_q;
  assign next_word       = next_word_q;

endmodule

// File: tb/tb_qbus_block_master.sv
module tb_qbus_block_master;

  logic clk, RINIT, RSYNC, RRPLY, RREF, RDMGI;
  logic TSYNC, TDIN, TDOUT, TDMR, TSACK, TBS7, TDMGO;
  logic start, write;
  logic [4:0] words;
  logic busy, done, nxm, assert_addr, assert_data, latch_read_data, next_word;

  int checks = 0;
  int errors = 0;

  // per-transfer observations filled in by run_xfer
  int st_done, st_nw, st_tdin_r, st_tdout_r, st_addr_r, st_tsync_r, st_tsack_r, st_tbs7_r;
  int st_tdin_len, st_latch_gap, st_tmo;
  logic [6:0] st_rst_t;
  logic st_rst_busy, st_rst_ad;

  qbus_block_master dut (
    .clk(clk), .RINIT(RINIT), .RSYNC(RSYNC), .RRPLY(RRPLY), .RREF(RREF), .RDMGI(RDMGI),
    .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TDMR(TDMR), .TSACK(TSACK), .TBS7(TBS7),
    .TDMGO(TDMGO), .start(start), .write(write), .words(words), .busy(busy), .done(done),
    .nxm(nxm), .assert_addr(assert_addr), .assert_data(assert_data),
    .latch_read_data(latch_read_data), .next_word(next_word)
  );

  initial clk = 1'b0;
  always #25 clk = ~clk;

  // Drives one transfer with a simple arbiter and slave model, sampling and
  // driving on negedges. The slave replies dly clocks after first seeing
  // its data strobe and carries RREF=rref throughout.
  task automatic run_xfer(input bit do_start, input bit wr, input logic [4:0] nw,
                          input bit rref, input int dly, input bit respond,
                          input int abort_tdout, input int restart_at, input int budget);
    int cyc, wait_cnt, rply_cyc, post;
    bit fin, data;
    bit p_tdin, p_tdout, p_aa, p_tsync, p_tsack, p_tbs7;
    st_done = 0; st_nw = 0; st_tdin_r = 0; st_tdout_r = 0; st_addr_r = 0;
    st_tsync_r = 0; st_tsack_r = 0; st_tbs7_r = 0; st_tdin_len = 0;
    st_latch_gap = -1; st_tmo = 0;
    cyc = 0; wait_cnt = 0; rply_cyc = -1; post = 0; fin = 0;
    @(negedge clk);
    RREF = rref;
    p_tdin = TDIN; p_tdout = TDOUT; p_aa = assert_addr; p_tsync = TSYNC;
    p_tsack = TSACK; p_tbs7 = TBS7;
    if (do_start) begin
      write = wr; words = nw; start = 1'b1;
    end
    @(negedge clk);
    while (!fin) begin
      if (TDIN && !p_tdin) st_tdin_r++;
      if (st_tdin_r == 1 && TDIN) st_tdin_len++;
      if (TDOUT && !p_tdout) st_tdout_r++;
      if (assert_addr && !p_aa) st_addr_r++;
      if (TSYNC && !p_tsync) st_tsync_r++;
      if (TSACK && !p_tsack) st_tsack_r++;
      if (TBS7 && !p_tbs7) st_tbs7_r++;
      if (next_word) st_nw++;
      if (done) st_done++;
      if (latch_read_data && st_latch_gap < 0 && rply_cyc >= 0) st_latch_gap = cyc - rply_cyc;
      p_tdin = TDIN; p_tdout = TDOUT; p_aa = assert_addr; p_tsync = TSYNC;
      p_tsack = TSACK; p_tbs7 = TBS7;
      if (abort_tdout > 0 && st_tdout_r == abort_tdout) begin
        RINIT = 1'b1;
        #1;
        st_rst_t    = {TSYNC, TDIN, TDOUT, TDMR, TSACK, TBS7, TDMGO};
        st_rst_busy = busy;
        st_rst_ad   = assert_data;
        fin = 1;
      end else begin
        if (TSACK) RDMGI = 1'b0;
        else if (TDMR) RDMGI = 1'b1;
        data = wr ? TDOUT : TDIN;
        if (data && !RRPLY) begin
          if (respond && wait_cnt == dly) begin
            RRPLY = 1'b1;
            if (rply_cyc < 0) rply_cyc = cyc;
          end
          wait_cnt++;
        end else if (!data && RRPLY) RRPLY = 1'b0;
        if (!data) wait_cnt = 0;
        if (restart_at > 0 && cyc == restart_at) begin
          start = 1'b1; write = ~wr; words = 5'd3;
        end else start = 1'b0;
        if (st_done > 0 && !busy) post++;
        if (post >= 3) fin = 1;
        cyc++;
        if (!fin && cyc >= budget) begin st_tmo = 1; fin = 1; end
        if (!fin) @(negedge clk);
      end
    end
    start = 1'b0; RREF = 1'b0; RRPLY = 1'b0; RDMGI = 1'b0;
  endtask

  task automatic test_reset;
    logic [13:0] outs;
    RINIT = 1'b1; RSYNC = 0; RRPLY = 0; RREF = 0; RDMGI = 1'b1;
    start = 0; write = 0; words = '0;
    repeat (3) @(negedge clk);
    outs = {TSYNC, TDIN, TDOUT, TDMR, TSACK, TBS7, TDMGO, busy, done, nxm,
            assert_addr, assert_data, latch_read_data, next_word};
    checks++;
    if (outs !== 14'h0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    RDMGI = 1'b0;
    RINIT = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || TDMR !== 1'b0) begin errors++; $display("FAIL post_reset_idle busy %b TDMR %b want 0 0", busy, TDMR); end
  endtask

  task automatic test_grant;
    bit glitch, acq;
    int n;
    RDMGI = 1'b1;
    #1;
    checks++;
    if (TDMGO !== 1'b1) begin errors++; $display("FAIL tdmgo_follow got %b want 1", TDMGO); end
    repeat (4) @(negedge clk);
    write = 0; words = 5'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({TDMGO, TDMR, busy} !== 3'b011) begin errors++; $display("FAIL grant_start got %b want 011", {TDMGO, TDMR, busy}); end
    glitch = 0; acq = 0;
    repeat (8) begin @(negedge clk); glitch |= TDMGO; acq |= TSACK; end
    RDMGI = 1'b0;
    repeat (5) begin @(negedge clk); glitch |= TDMGO; acq |= TSACK; end
    checks++;
    if (glitch !== 1'b0) begin errors++; $display("FAIL tdmgo_glitch got %b want 0", glitch); end
    checks++;
    if (acq !== 1'b0) begin errors++; $display("FAIL stale_grant_used got %b want 0", acq); end
    RDMGI = 1'b1;
    n = 0;
    while (!TSACK && n < 10) begin @(negedge clk); n++; end
    checks++;
    if (TSACK !== 1'b1) begin errors++; $display("FAIL new_grant_acq got %b want 1", TSACK); end
    run_xfer(0, 0, 5'd1, 0, 2, 1, 0, 0, 100);
    checks++;
    if (st_tmo != 0 || st_done != 1 || st_nw != 1) begin
      errors++; $display("FAIL grant_xfer tmo %0d done %0d nw %0d want 0 1 1", st_tmo, st_done, st_nw);
    end
  endtask

  task automatic test_single_read;
    run_xfer(1, 0, 5'd1, 0, 2, 1, 0, 0, 100);
    checks++;
    if (st_tmo != 0) begin errors++; $display("FAIL sr_timeout got %0d want 0", st_tmo); end
    checks++;
    if (st_tdin_len != 6) begin errors++; $display("FAIL sr_tdin_len got %0d want 6", st_tdin_len); end
    checks++;
    if (st_latch_gap != 3) begin errors++; $display("FAIL sr_latch_gap got %0d want 3", st_latch_gap); end
    checks++;
    if (st_nw != 1 || st_done != 1 || st_addr_r != 1 || st_tbs7_r != 0) begin
      errors++; $display("FAIL sr_counts nw %0d done %0d addr %0d bs7 %0d want 1 1 1 0", st_nw, st_done, st_addr_r, st_tbs7_r);
    end
    checks++;
    if ({TSACK, busy, nxm} !== 3'b000) begin errors++; $display("FAIL sr_end got %b want 000", {TSACK, busy, nxm}); end
  endtask

  task automatic test_start_ignored;
    run_xfer(1, 0, 5'd1, 0, 2, 1, 0, 3, 100);
    checks++;
    if (st_nw != 1 || st_tdout_r != 0 || st_done != 1 || busy !== 1'b0) begin
      errors++; $display("FAIL busy_start nw %0d tdout %0d done %0d busy %b want 1 0 1 0", st_nw, st_tdout_r, st_done, busy);
    end
  endtask

  task automatic test_block_write;
    run_xfer(1, 1, 5'd4, 1, 1, 1, 0, 0, 300);
    checks++;
    if (st_tmo != 0 || st_done != 1) begin errors++; $display("FAIL bw_done tmo %0d done %0d want 0 1", st_tmo, st_done); end
    checks++;
    if (st_tsync_r != 1 || st_addr_r != 1 || st_tbs7_r != 1) begin
      errors++; $display("FAIL bw_addr tsync %0d addr %0d bs7 %0d want 1 1 1", st_tsync_r, st_addr_r, st_tbs7_r);
    end
    checks++;
    if (st_tdout_r != 4 || st_nw != 4) begin errors++; $display("FAIL bw_words tdout %0d nw %0d want 4 4", st_tdout_r, st_nw); end
  endtask

  task automatic test_three_read;
    run_xfer(1, 0, 5'd3, 0, 1, 1, 0, 0, 300);
    checks++;
    if (st_tmo != 0 || st_done != 1) begin errors++; $display("FAIL r3_done tmo %0d done %0d want 0 1", st_tmo, st_done); end
    checks++;
    if (st_addr_r != 3 || st_tsync_r != 3 || st_tbs7_r != 2) begin
      errors++; $display("FAIL r3_addr addr %0d tsync %0d bs7 %0d want 3 3 2", st_addr_r, st_tsync_r, st_tbs7_r);
    end
    checks++;
    if (st_tsack_r != 1 || st_nw != 3 || st_tdin_r != 3) begin
      errors++; $display("FAIL r3_words tsack %0d nw %0d tdin %0d want 1 3 3", st_tsack_r, st_nw, st_tdin_r);
    end
  endtask

  task automatic test_clamp;
    run_xfer(1, 0, 5'd0, 0, 1, 1, 0, 0, 100);
    checks++;
    if (st_nw != 1 || st_tbs7_r != 0 || st_done != 1) begin
      errors++; $display("FAIL clamp_zero nw %0d bs7 %0d done %0d want 1 0 1", st_nw, st_tbs7_r, st_done);
    end
    run_xfer(1, 1, 5'd31, 1, 0, 1, 0, 0, 800);
    checks++;
    if (st_nw != 16 || st_tdout_r != 16 || st_done != 1 || st_tmo != 0) begin
      errors++; $display("FAIL clamp_max nw %0d tdout %0d done %0d tmo %0d want 16 16 1 0", st_nw, st_tdout_r, st_done, st_tmo);
    end
  endtask

  task automatic test_timeout;
    run_xfer(1, 0, 5'd2, 0, 0, 0, 0, 0, 400);
    checks++;
    if (st_tdin_len != 200) begin errors++; $display("FAIL nxm_tdin_len got %0d want 200", st_tdin_len); end
    checks++;
    if (st_done != 1 || st_nw != 0 || st_tmo != 0) begin
      errors++; $display("FAIL nxm_counts done %0d nw %0d tmo %0d want 1 0 0", st_done, st_nw, st_tmo);
    end
    checks++;
    if ({nxm, TSACK, TSYNC, busy} !== 4'b1000) begin errors++; $display("FAIL nxm_end got %b want 1000", {nxm, TSACK, TSYNC, busy}); end
    repeat (5) @(negedge clk);
    checks++;
    if (nxm !== 1'b1) begin errors++; $display("FAIL nxm_sticky got %b want 1", nxm); end
    run_xfer(1, 0, 5'd1, 0, 2, 1, 0, 0, 100);
    checks++;
    if (nxm !== 1'b0 || st_done != 1) begin errors++; $display("FAIL nxm_clear nxm %b done %0d want 0 1", nxm, st_done); end
  endtask

  task automatic test_rinit_mid;
    int d;
    run_xfer(1, 1, 5'd4, 1, 1, 1, 2, 0, 300);
    checks++;
    if (st_tmo != 0 || st_nw != 1) begin errors++; $display("FAIL rinit_reach tmo %0d nw %0d want 0 1", st_tmo, st_nw); end
    checks++;
    if (st_rst_t !== 7'h0 || st_rst_busy !== 1'b0 || st_rst_ad !== 1'b0) begin
      errors++; $display("FAIL rinit_outs t %b busy %b ad %b want 0 0 0", st_rst_t, st_rst_busy, st_rst_ad);
    end
    d = 0;
    repeat (5) begin @(negedge clk); if (done) d++; end
    RINIT = 1'b0;
    repeat (3) begin @(negedge clk); if (done) d++; end
    checks++;
    if (d != 0 || busy !== 1'b0) begin errors++; $display("FAIL rinit_no_done done %0d busy %b want 0 0", d, busy); end
  endtask

  initial begin
    test_reset;
    test_grant;
    test_single_read;
    test_start_ignored;
    test_block_write;
    test_three_read;
    test_clamp;
    test_timeout;
    test_rinit_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
